// File: rtl/imem_loader_if.sv
// Boot-stream and instruction-memory write bundle for the program loader.
// The loader takes the slave view; the stream source / memory side takes the master view.
interface imem_loader_if #(
  parameter int ADDR_W = 10
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [7:0]        imem_wdata;

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output imem_we,
    output imem_addr,
    output imem_wdata
  );

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  imem_we,
    input  imem_addr,
    input  imem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Boot-time loader: parses a LEN_LO/LEN_HI/payload/XOR-checksum frame, writes the payload
// into instruction memory from address 0 and releases the processor reset on a good checksum.
module imem_loader #(
  parameter int IMEM_BYTES = 1024,
  parameter int ADDR_W     = 10
) (
  input  logic              clk,
  input  logic              reset,
  imem_loader_if.slave      bus,
  output logic              cpu_reset,
  output logic              load_done,
  output logic              load_error,
  output logic [ADDR_W:0]   bytes_loaded
);

  localparam logic [2:0] S_LEN_LO = 3'd0;
  localparam logic [2:0] S_LEN_HI = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_CHECK  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;
  localparam logic [2:0] S_ERROR  = 3'd5;

  localparam logic [15:0] CAP_LEN = 16'(IMEM_BYTES);

  logic [2:0]      state_q, state_d;
  logic [15:0]     len_q, len_d;
  logic [ADDR_W:0] ptr_q, ptr_d;
  logic [7:0]      xor_q, xor_d;
  logic            cpu_reset_q, load_done_q, load_error_q;

  logic            in_ready_s;
  logic            accept_s;
  logic            last_s;
  logic [ADDR_W:0] ptr_inc_s;

  // Where a frame goes once its full 16-bit length is known.
  function automatic logic [2:0] len_next_state(input logic [15:0] len);
    if (len > CAP_LEN) begin
      return S_ERROR;
    end else if (len == 16'd0) begin
      return S_CHECK;
    end else begin
      return S_DATA;
    end
  endfunction

  // Handshake: ready in every non-terminal state; reset suppresses any transfer.
  always_comb begin
    case (state_q)
      S_LEN_LO, S_LEN_HI, S_DATA, S_CHECK: in_ready_s = 1'b1;
      default:                             in_ready_s = 1'b0;
    endcase
    accept_s  = bus.in_valid && in_ready_s && !reset;
    ptr_inc_s = ptr_q + {{ADDR_W{1'b0}}, 1'b1};
    last_s    = ({{(15-ADDR_W){1'b0}}, ptr_inc_s} == len_q);
  end

  // Frame parser next-state, pointer and checksum accumulator.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    ptr_d   = ptr_q;
    xor_d   = xor_q;
    case (state_q)
      S_LEN_LO: begin
        if (accept_s) begin
          len_d   = {len_q[15:8], bus.in_data};
          state_d = S_LEN_HI;
        end else begin
          state_d = S_LEN_LO;
        end
      end
      S_LEN_HI: begin
        if (accept_s) begin
          len_d   = {bus.in_data, len_q[7:0]};
          state_d = len_next_state({bus.in_data, len_q[7:0]});
        end else begin
          state_d = S_LEN_HI;
        end
      end
      S_DATA: begin
        if (accept_s) begin
          xor_d   = xor_q ^ bus.in_data;
          ptr_d   = ptr_inc_s;
          state_d = last_s ? S_CHECK : S_DATA;
        end else begin
          state_d = S_DATA;
        end
      end
      S_CHECK: begin
        if (accept_s) begin
          state_d = (bus.in_data == xor_q) ? S_DONE : S_ERROR;
        end else begin
          state_d = S_CHECK;
        end
      end
      S_DONE:  state_d = S_DONE;
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_ERROR;
    endcase
  end

  // Parser state and registered status; status follows the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_LEN_LO;
      len_q        <= 16'd0;
      ptr_q        <= '0;
      xor_q        <= 8'd0;
      cpu_reset_q  <= 1'b1;
      load_done_q  <= 1'b0;
      load_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      ptr_q        <= ptr_d;
      xor_q        <= xor_d;
      cpu_reset_q  <= (state_d != S_DONE);
      load_done_q  <= (state_d == S_DONE);
      load_error_q <= (state_d == S_ERROR);
    end
  end

  // Zero-latency write path: the byte lands on the edge that accepts it.
  always_comb begin
    bus.in_ready   = in_ready_s;
    bus.imem_we    = accept_s && (state_q == S_DATA);
    bus.imem_addr  = ptr_q[ADDR_W-1:0];
    bus.imem_wdata = bus.in_data;
  end

  assign cpu_reset    = cpu_reset_q;
  assign load_done    = load_done_q;
  assign load_error   = load_error_q;
  assign bytes_loaded = ptr_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader: good/bad frames, empty/overflow lengths,
// backpressure gaps, reset mid-payload and a full-capacity load.
module tb_imem_loader;
  localparam int IMEM_BYTES = 1024;
  localparam int ADDR_W     = 10;

  logic              clk;
  logic              reset;
  logic              cpu_reset;
  logic              load_done;
  logic              load_error;
  logic [ADDR_W:0]   bytes_loaded;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(.IMEM_BYTES(IMEM_BYTES), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .cpu_reset    (cpu_reset),
    .load_done    (load_done),
    .load_error   (load_error),
    .bytes_loaded (bytes_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  int          wr_count = 0;
  int          bad_we   = 0;
  logic [31:0] wa [0:4095];
  logic [7:0]  wd [0:4095];
  int          wc [0:4095];
  logic [7:0]  mem [0:IMEM_BYTES-1];
  logic [7:0]  frame [$];

  // Memory model and write log fed from the DUT write port.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (bus.imem_we) begin
      wa[wr_count]       = 32'(bus.imem_addr);
      wd[wr_count]       = bus.imem_wdata;
      wc[wr_count]       = cyc;
      mem[bus.imem_addr] = bus.imem_wdata;
      wr_count           = wr_count + 1;
      if (!(bus.in_valid && bus.in_ready) || reset) bad_we = bad_we + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (obs === exp) begin
      n_pass = n_pass + 1;
    end else begin
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Streams the global frame with 'gap' idle cycles before each byte, then drops valid.
  task automatic send_frame(input int gap);
    foreach (frame[i]) begin
      repeat (gap) begin
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_data  = 8'hEE;
      end
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = frame[i];
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  int base;

  initial begin
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("rst_load_done", 32'(load_done), 32'd0);
    check("rst_load_error", 32'(load_error), 32'd0);
    check("rst_bytes", 32'(bytes_loaded), 32'd0);
    check("rst_we", 32'(bus.imem_we), 32'd0);

    // Good frame, back-to-back
    base  = wr_count;
    frame = '{8'h04, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
    send_frame(0);
    check("good_nwr", 32'(wr_count - base), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("good_addr", wa[base+i], 32'(i));
      check("good_data", 32'(wd[base+i]), 32'(i + 1));
    end
    check("good_consec", 32'(wc[base+3] - wc[base]), 32'd3);
    check("good_done", 32'(load_done), 32'd1);
    check("good_cpu_reset", 32'(cpu_reset), 32'd0);
    check("good_error", 32'(load_error), 32'd0);
    check("good_bytes", 32'(bytes_loaded), 32'd4);
    check("good_ready", 32'(bus.in_ready), 32'd0);

    // Bad checksum
    do_reset();
    base  = wr_count;
    frame = '{8'h04, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    send_frame(0);
    check("bad_error", 32'(load_error), 32'd1);
    check("bad_done", 32'(load_done), 32'd0);
    check("bad_cpu_reset", 32'(cpu_reset), 32'd1);
    check("bad_ready", 32'(bus.in_ready), 32'd0);
    base = wr_count;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h5A;
      #1;
      check("bad_no_we", 32'(bus.imem_we), 32'd0);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("bad_no_writes", 32'(wr_count - base), 32'd0);
    check("bad_error_sticky", 32'(load_error), 32'd1);

    // Empty frame
    do_reset();
    base  = wr_count;
    frame = '{8'h00, 8'h00, 8'h00};
    send_frame(0);
    check("empty_done", 32'(load_done), 32'd1);
    check("empty_cpu_reset", 32'(cpu_reset), 32'd0);
    check("empty_nwr", 32'(wr_count - base), 32'd0);
    check("empty_bytes", 32'(bytes_loaded), 32'd0);

    // Length overflow (1025)
    do_reset();
    base  = wr_count;
    frame = '{8'h01, 8'h04};
    send_frame(0);
    check("ovf_error", 32'(load_error), 32'd1);
    check("ovf_done", 32'(load_done), 32'd0);
    check("ovf_cpu_reset", 32'(cpu_reset), 32'd1);
    check("ovf_ready", 32'(bus.in_ready), 32'd0);
    check("ovf_nwr", 32'(wr_count - base), 32'd0);

    // Backpressure gaps of 3 idle cycles
    do_reset();
    base  = wr_count;
    frame = '{8'h04, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
    send_frame(3);
    check("gap_nwr", 32'(wr_count - base), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("gap_addr", wa[base+i], 32'(i));
      check("gap_data", 32'(wd[base+i]), 32'(i + 1));
    end
    check("gap_spacing", 32'(wc[base+3] - wc[base]), 32'd12);
    check("gap_done", 32'(load_done), 32'd1);
    check("gap_cpu_reset", 32'(cpu_reset), 32'd0);
    check("gap_bytes", 32'(bytes_loaded), 32'd4);

    // Reset mid-payload with a byte presented during reset
    do_reset();
    base  = wr_count;
    frame = '{8'h08, 8'h00, 8'hAA, 8'hBB};
    send_frame(0);
    check("midrst_bytes_pre", 32'(bytes_loaded), 32'd2);
    @(negedge clk);
    reset        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hCC;
    @(negedge clk);
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    check("midrst_nwr", 32'(wr_count - base), 32'd2);
    check("midrst_mem2", 32'(mem[2]), 32'h03);
    check("midrst_bytes", 32'(bytes_loaded), 32'd0);
    check("midrst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("midrst_ready", 32'(bus.in_ready), 32'd1);
    frame = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33};
    send_frame(0);
    check("midrst_mem0", 32'(mem[0]), 32'h11);
    check("midrst_mem1", 32'(mem[1]), 32'h22);
    check("midrst_done", 32'(load_done), 32'd1);
    check("midrst_bytes2", 32'(bytes_loaded), 32'd2);

    // Full capacity: 1024 bytes of i[7:0], checksum 00
    do_reset();
    base = wr_count;
    frame.delete();
    frame.push_back(8'h00);
    frame.push_back(8'h04);
    for (int i = 0; i < IMEM_BYTES; i++) begin
      logic [31:0] iv;
      iv = 32'(i);
      frame.push_back(iv[7:0]);
    end
    frame.push_back(8'h00);
    send_frame(0);
    check("full_nwr", 32'(wr_count - base), 32'd1024);
    check("full_first_addr", wa[base], 32'd0);
    check("full_last_addr", wa[base+1023], 32'd1023);
    check("full_mem1023", 32'(mem[1023]), 32'hFF);
    check("full_mem300", 32'(mem[300]), 32'h2C);
    check("full_bytes", 32'(bytes_loaded), 32'd1024);
    check("full_done", 32'(load_done), 32'd1);
    check("full_cpu_reset", 32'(cpu_reset), 32'd0);

    check("we_only_on_transfer", 32'(bad_we), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time program loader upstream of the single-cycle processor's instruction memory.
- Accepts a framed byte stream over a valid/ready handshake and writes the payload bytes sequentially into instruction memory from byte address 0.
- Verifies an XOR checksum, then releases the processor from reset.
- Replaces the simulation-only file preload with a path that is also usable in hardware.

Parameters:
IMEM_BYTES, 1024, instruction memory capacity in bytes; upper bound on payload length
ADDR_W, 10, instruction memory byte-address width; must satisfy 2**ADDR_W >= IMEM_BYTES

Ports:
clk  input  1  system clock; all state updates on posedge
reset  input  1  synchronous, active-high reset
in_valid  input  1  stream byte present
in_data  input  8  stream byte
in_ready  output  1  loader accepts a byte this cycle
imem_we  output  1  instruction-memory byte write enable
imem_addr  output  ADDR_W  instruction-memory byte address
imem_wdata  output  8  instruction-memory write byte
cpu_reset  output  1  held high until a load completes successfully; drives the processor reset
load_done  output  1  sticky; a frame loaded with a good checksum
load_error  output  1  sticky; length overflow or checksum mismatch
bytes_loaded  output  ADDR_W+1  payload bytes written so far

Behaviour:
- Frame format: LEN_LO, LEN_HI (16-bit little-endian byte count N), then N payload bytes, then 1 checksum byte. The checksum byte equals the XOR of all payload bytes.
- A byte transfers only on a cycle where in_valid && in_ready.
- Reset values: state=LEN_LO, ptr=0, xor_acc=0, cpu_reset=1, load_done=0, load_error=0, bytes_loaded=0, imem_we=0.
- States and transitions:
  - LEN_LO: on a transfer, latch len[7:0], then go to LEN_HI.
  - LEN_HI: on a transfer, latch len[15:8]. Next state depends on the full 16-bit length:
    - len > IMEM_BYTES: go to ERROR.
    - len == 0: go to CHECK.
    - otherwise: go to DATA.
  - DATA: on each transfer:
    - write the byte at ptr;
    - xor_acc ^= in_data;
    - increment ptr and bytes_loaded;
    - when this transfer is byte N, go to CHECK.
  - CHECK: on a transfer, go to DONE if in_data == xor_acc, else ERROR.
  - DONE: terminal. in_ready=0, load_done=1, cpu_reset=0.
  - ERROR: terminal. in_ready=0, load_error=1, cpu_reset=1.
  - DONE and ERROR are left only by reset.
- in_ready is combinational: 1 in LEN_LO, LEN_HI, DATA and CHECK; 0 in DONE and ERROR. It does not depend on in_valid.
- Memory write path, combinational in DATA:
  - imem_we = in_valid && in_ready;
  - imem_addr = ptr[ADDR_W-1:0];
  - imem_wdata = in_data.
  - Zero-latency: the write lands on the same clock edge that accepts the byte.
  - Outside DATA, imem_we=0.
- Status outputs (cpu_reset, load_done, load_error) are registered. They change on the clock edge that enters DONE or ERROR, i.e. visible in the cycle after the checksum byte is accepted (or after LEN_HI, for overflow).
- Width rules:
  - len is 16 bits; the comparison against IMEM_BYTES uses the full 16 bits.
  - ptr never wraps, because len <= IMEM_BYTES is enforced before DATA.
  - len == IMEM_BYTES is legal; the last write goes to IMEM_BYTES-1.
- Idle cycles (in_valid=0) in any state: no state change, no write, accumulators hold.
- Reset mid-frame returns to LEN_LO with cpu_reset=1. Memory contents already written are not cleared, and the next frame overwrites from address 0.
- Reset in the same cycle as a transfer: reset wins; the byte is dropped and no write occurs.
- in_data is ignored whenever in_valid=0.

Test Plan:
- Good frame: stream 04,00,01,02,03,04,04 back-to-back. Required:
  - writes imem[0..3]=01,02,03,04 on 4 consecutive cycles;
  - load_done=1, cpu_reset=0 one cycle after the last byte;
  - bytes_loaded=4.
- Bad checksum: stream 04,00,01,02,03,04,05. Required:
  - load_error=1, load_done=0, cpu_reset stays 1;
  - in_ready=0 afterwards;
  - further in_valid produces no writes.
- Empty and overflow lengths:
  - stream 00,00,00 → load_done=1 with zero writes and bytes_loaded=0;
  - after reset, stream 01,04 (N=1025) with IMEM_BYTES=1024 → load_error=1 immediately after LEN_HI, no imem_we pulse.
- Backpressure gaps: good 4-byte frame with in_valid low for 3 cycles between every byte. Required: identical memory contents and final status to the back-to-back case, and imem_we high only on transfer cycles.
- Reset mid-payload:
  - stream 08,00,AA,BB, then assert reset for 1 cycle while in_valid=1 with CC. Required: CC not written, ptr back to 0.
  - then stream 02,00,11,22,33. Required: imem[0]=11, imem[1]=22, load_done=1.
- Full capacity: N=1024, payload byte i = i[7:0], checksum 00. Required: imem[1023]=FF, bytes_loaded=1024, load_done=1, no write at any address >= 1024.
